// File: rtl/lane_scan_pkg.sv
// Shared types and helpers for the lane scan multiplexer: FSM states,
// frame length computation and zero-padded slice extraction.
package lane_scan_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, TICK, LATCH} state_t;

   localparam int BUS_MAX   = 1024;
   localparam int SLICE_MAX = 64;

   function automatic int beats_f(input int in_w, input int out_w, input int io_w, input int lane_w);
      int m;
      m = in_w;
      if (out_w > m) m = out_w;
      if (io_w > m) m = io_w;
      return (m + lane_w - 1) / lane_w;
   endfunction

   // Bits past bus_w read back as zero so the last slice of a narrow bus is padded.
   function automatic logic [SLICE_MAX-1:0] slice_get(input logic [BUS_MAX-1:0] bus, input int k,
                                                      input int lane_w, input int bus_w);
      logic [SLICE_MAX-1:0] s;
      s = '0;
      for (int b = 0; b < SLICE_MAX; b++) begin
         int idx;
         idx = k * lane_w + b;
         if (b < lane_w && idx < bus_w && idx < BUS_MAX) s[b] = bus[idx];
      end
      return s;
   endfunction

endpackage

// File: rtl/lane_slice_reg.sv
// Wide register written one lane-slice at a time (or loaded whole) and read
// back one lane-slice at a time.
module lane_slice_reg
   import lane_scan_pkg::*;
#(
   parameter int W      = 8,
   parameter int LANE_W = 8,
   parameter int IDX_W  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [LANE_W-1:0] wr_data,
   input  logic              ld_en,
   input  logic [W-1:0]      ld_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [LANE_W-1:0] rd_data,
   output logic [W-1:0]      q
);

   logic [W+LANE_W-1:0] sh_data, sh_mask;
   logic [W-1:0]        wmask, wval;

   // Shifting through a padded vector drops slice bits that land past W.
   always_comb begin
      sh_data = (W + LANE_W)'(wr_data) << (LANE_W * int'(wr_idx));
      sh_mask = (W + LANE_W)'({LANE_W{1'b1}}) << (LANE_W * int'(wr_idx));
      wval    = sh_data[W-1:0];
      wmask   = sh_mask[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)        q <= '0;
      else if (ld_en) q <= ld_data;
      else if (wr_en) q <= (q & ~wmask) | (wval & wmask);
   end

   assign rd_data = LANE_W'(slice_get(BUS_MAX'(q), int'(rd_idx), LANE_W, W));

endmodule

// File: rtl/lane_scan_mux.sv
// Time-multiplexes a wide core's buses over narrow pad lanes, one slice per
// clock, then enables the core for one cycle and snapshots its outputs.
module lane_scan_mux
   import lane_scan_pkg::*;
#(
   parameter int  IN_W   = 20,
   parameter int  OUT_W  = 12,
   parameter int  IO_W   = 8,
   parameter int  LANE_W = 8,
   parameter int  CNT_W  = 16,
   localparam int BEATS  = beats_f(IN_W, OUT_W, IO_W, LANE_W),
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   input  logic [LANE_W-1:0] lane_in,
   output logic [LANE_W-1:0] lane_out,
   input  logic [LANE_W-1:0] lane_io_in,
   output logic [LANE_W-1:0] lane_io_out,
   output logic [LANE_W-1:0] lane_io_oe,
   output logic [BIDX_W-1:0] beat_idx,
   output logic              frame_start,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              core_ce,
   output logic [IN_W-1:0]   core_in,
   input  logic [OUT_W-1:0]  core_out,
   output logic [IO_W-1:0]   core_io_in,
   input  logic [IO_W-1:0]   core_io_out,
   input  logic [IO_W-1:0]   core_io_oe
);

   state_t            state, state_nx;
   logic [BIDX_W-1:0] beat, beat_nx;
   logic              scan, latch, last_beat;

   assign scan      = (state == SCAN);
   assign latch     = (state == LATCH);
   assign last_beat = (beat == BIDX_W'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat      <= '0;
         frame_cnt <= '0;
      end else begin
         state <= state_nx;
         beat  <= beat_nx;
         if (latch) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      beat_nx  = '0;
      case (state)
         IDLE:  if (run || step) state_nx = SCAN;
         SCAN: begin
            if (last_beat) state_nx = TICK;
            else           beat_nx  = beat + 1'b1;
         end
         TICK:  state_nx = LATCH;
         LATCH: state_nx = run ? SCAN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   logic [LANE_W-1:0] out_slice, io_out_slice, oe_slice;
   logic [LANE_W-1:0] unused_in_rd, unused_io_in_rd;
   logic [OUT_W-1:0]  unused_out_q;
   logic [IO_W-1:0]   unused_io_out_q, unused_oe_q;

   lane_slice_reg #(.W(IN_W), .LANE_W(LANE_W), .IDX_W(BIDX_W)) u_in_sh (
      .clk(clk), .rst(rst), .wr_en(scan), .wr_idx(beat), .wr_data(lane_in),
      .ld_en(1'b0), .ld_data('0), .rd_idx(beat), .rd_data(unused_in_rd), .q(core_in)
   );

   // Bits the core is driving onto the pad read back as 0, not as the echo.
   lane_slice_reg #(.W(IO_W), .LANE_W(LANE_W), .IDX_W(BIDX_W)) u_io_in_sh (
      .clk(clk), .rst(rst), .wr_en(scan), .wr_idx(beat), .wr_data(lane_io_in & ~lane_io_oe),
      .ld_en(1'b0), .ld_data('0), .rd_idx(beat), .rd_data(unused_io_in_rd), .q(core_io_in)
   );

   lane_slice_reg #(.W(OUT_W), .LANE_W(LANE_W), .IDX_W(BIDX_W)) u_out_sh (
      .clk(clk), .rst(rst), .wr_en(1'b0), .wr_idx('0), .wr_data('0),
      .ld_en(latch), .ld_data(core_out), .rd_idx(beat), .rd_data(out_slice), .q(unused_out_q)
   );

   lane_slice_reg #(.W(IO_W), .LANE_W(LANE_W), .IDX_W(BIDX_W)) u_io_out_sh (
      .clk(clk), .rst(rst), .wr_en(1'b0), .wr_idx('0), .wr_data('0),
      .ld_en(latch), .ld_data(core_io_out), .rd_idx(beat), .rd_data(io_out_slice), .q(unused_io_out_q)
   );

   lane_slice_reg #(.W(IO_W), .LANE_W(LANE_W), .IDX_W(BIDX_W)) u_oe_sh (
      .clk(clk), .rst(rst), .wr_en(1'b0), .wr_idx('0), .wr_data('0),
      .ld_en(latch), .ld_data(core_io_oe), .rd_idx(beat), .rd_data(oe_slice), .q(unused_oe_q)
   );

   assign lane_out    = scan ? out_slice : '0;
   assign lane_io_oe  = scan ? oe_slice : '0;
   assign lane_io_out = io_out_slice & lane_io_oe;
   assign beat_idx    = beat;
   assign frame_start = scan && (beat == '0);
   assign busy        = (state != IDLE);
   assign core_ce     = (state == TICK);

endmodule

// File: tb/tb_lane_scan_mux.sv
// Bench for lane_scan_mux: table-driven run-mode frames, reset and step
// sequences, with a core_ce-triggered scoreboard for the core-side buses.
module tb_lane_scan_mux;

   logic        clk, rst, run, step;
   logic [7:0]  lane_in, lane_out, lane_io_in, lane_io_out, lane_io_oe;
   logic [1:0]  beat_idx;
   logic        frame_start, busy, core_ce;
   logic [15:0] frame_cnt;
   logic [19:0] core_in;
   logic [11:0] core_out;
   logic [7:0]  core_io_in, core_io_out, core_io_oe;

   lane_scan_mux dut (
      .clk(clk), .rst(rst), .run(run), .step(step),
      .lane_in(lane_in), .lane_out(lane_out),
      .lane_io_in(lane_io_in), .lane_io_out(lane_io_out), .lane_io_oe(lane_io_oe),
      .beat_idx(beat_idx), .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt),
      .core_ce(core_ce), .core_in(core_in), .core_out(core_out),
      .core_io_in(core_io_in), .core_io_out(core_io_out), .core_io_oe(core_io_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0][7:0] li;
      logic [7:0]      lio;
      logic [11:0]     cout;
      logic [7:0]      cio_out, cio_oe;
      logic [19:0]     exp_in;
      logic [7:0]      exp_io_in;
      logic [2:0][7:0] exp_lo;
      logic [7:0]      exp_oe0, exp_io0;
   } vec_t;

   typedef struct {
      logic [19:0] ci;
      logic [7:0]  cio;
   } sb_t;

   int   tests = 0;
   int   fails = 0;
   sb_t  sb[$];
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [23:0] li, input logic [7:0] lio, input logic [11:0] cout,
                               input logic [7:0] cio_out, input logic [7:0] cio_oe, input logic [19:0] exp_in,
                               input logic [7:0] exp_io_in, input logic [23:0] exp_lo,
                               input logic [7:0] exp_oe0, input logic [7:0] exp_io0);
      vec_t v;
      v.li = li; v.lio = lio; v.cout = cout; v.cio_out = cio_out; v.cio_oe = cio_oe;
      v.exp_in = exp_in; v.exp_io_in = exp_io_in; v.exp_lo = exp_lo;
      v.exp_oe0 = exp_oe0; v.exp_io0 = exp_io0;
      return v;
   endfunction

   // Core-side scoreboard: each core_ce must consume one expected record.
   always @(negedge clk) begin
      if (core_ce) begin
         if (sb.size() == 0) begin
            chk("unexpected_core_ce", 32'd1, 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("core_in_at_ce", 32'(core_in), 32'(e.ci));
            chk("core_io_in_at_ce", 32'(core_io_in), 32'(e.cio));
         end
      end
   end

   // Enters on SCAN beat 0; leaves on the cycle after LATCH.
   task automatic run_frame(input int i, input bit last);
      vec_t v;
      v = tbl[i];
      for (int b = 0; b < 3; b++) begin
         chk("frame_start", 32'(frame_start), 32'(b == 0));
         chk("beat_idx", 32'(beat_idx), 32'(b));
         chk("lane_out", 32'(lane_out), 32'(v.exp_lo[b]));
         chk("lane_io_oe", 32'(lane_io_oe), (b == 0) ? 32'(v.exp_oe0) : 32'd0);
         chk("lane_io_out", 32'(lane_io_out), (b == 0) ? 32'(v.exp_io0) : 32'd0);
         lane_in    = v.li[b];
         lane_io_in = v.lio;
         if (b == 2) sb.push_back('{v.exp_in, v.exp_io_in});
         if (last && b == 1) run = 1'b0;
         tick();
      end
      chk("tick_core_ce", 32'(core_ce), 32'd1);
      chk("tick_lane_out_zero", 32'(lane_out), 32'd0);
      core_out    = v.cout;
      core_io_out = v.cio_out;
      core_io_oe  = v.cio_oe;
      tick();
      chk("latch_core_ce", 32'(core_ce), 32'd0);
      chk("latch_busy", 32'(busy), 32'd1);
      tick();
      chk("frame_cnt", 32'(frame_cnt), 32'(i + 1));
   endtask

   initial begin
      int busy_n;
      tbl[0] = mk(24'h0F3CA5, 8'hFF, 12'hABC, 8'h5A, 8'hF0, 20'hF3CA5, 8'hFF, 24'h000000, 8'h00, 8'h00);
      tbl[1] = mk(24'h332211, 8'hFF, 12'h123, 8'hC3, 8'h0F, 20'h32211, 8'h0F, 24'h000ABC, 8'hF0, 8'h50);
      tbl[2] = mk(24'hFFFF00, 8'h3C, 12'hFFF, 8'hFF, 8'h00, 20'hFFF00, 8'h30, 24'h000123, 8'h0F, 8'h03);
      tbl[3] = mk(24'h8000FF, 8'hA5, 12'h000, 8'h00, 8'hFF, 20'h000FF, 8'hA5, 24'h000FFF, 8'h00, 8'h00);
      tbl[4] = mk(24'h030201, 8'h5A, 12'h5A5, 8'h00, 8'h00, 20'h30201, 8'h00, 24'h000000, 8'hFF, 8'h00);

      rst = 1'b1; run = 1'b0; step = 1'b0;
      lane_in = '0; lane_io_in = '0; core_out = '0; core_io_out = '0; core_io_oe = '0;
      tick(); tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         chk("idle_outputs_zero", 32'({busy, core_ce, frame_start, beat_idx, lane_out, lane_io_oe, lane_io_out}), 32'd0);
         tick();
      end
      chk("idle_core_in", 32'(core_in), 32'd0);
      chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);

      // Reset landing on beat 1 must abort the frame without a tick.
      run = 1'b1;
      tick();
      lane_in = 8'h77;
      tick();
      chk("abort_beat_idx", 32'(beat_idx), 32'd1);
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_core_in", 32'(core_in), 32'd0);
      chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
      run = 1'b0; rst = 1'b0;
      tick(); tick();
      chk("abort_stays_idle", 32'(busy), 32'd0);

      run = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) run_frame(i, i == 4);
      chk("run_off_idle", 32'(busy), 32'd0);
      chk("run_off_lane_out", 32'(lane_out), 32'd0);

      // Single step; a second pulse during SCAN must not queue another frame.
      lane_in = 8'h5A; lane_io_in = 8'h5A;
      sb.push_back('{20'hA5A5A, 8'h5A});
      step = 1'b1;
      tick();
      step = 1'b0;
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy) busy_n++;
         if (i == 0) chk("step_lane_out_b0", 32'(lane_out), 32'h0A5);
         step = (i == 1);
         tick();
      end
      step = 1'b0;
      chk("step_busy_cycles", 32'(busy_n), 32'd5);
      chk("step_frame_cnt", 32'(frame_cnt), 32'd6);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
